// File: rtl/bcd_addsub_serial_if.sv
// rtl/bcd_addsub_serial_if.sv - request/result bundle for the digit-serial BCD adder/subtractor
interface bcd_addsub_serial_if #(
  parameter int DIGITS = 4
) ();
  logic                  start;
  logic                  op;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cy;
  logic                  err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cy, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cy, err
  );
endinterface

// File: rtl/bcd_addsub_serial.sv
// rtl/bcd_addsub_serial.sv - digit-serial BCD add/sub, one digit per clock, LSD first
// Subtraction runs as a + (9's complement of b) + 1, so the final carry is the inverted borrow.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_b,
  bcd_addsub_serial_if.slave     bus
);
  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             op_q, op_d;
  logic             c_q, c_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     result_q, result_d;
  logic             cy_q, cy_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic             any_bad;
  logic [3:0]       a_dig;
  logic [3:0]       b_dig;
  logic [3:0]       bi;
  logic [4:0]       s;
  logic [3:0]       digit;
  logic             c_out;

  // Scans the live operands so a bad digit is caught on the accept edge itself.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
        any_bad = 1'b1;
      end
    end
  end

  always_comb begin
    a_dig = a_q[4*int'(idx_q) +: 4];
    b_dig = b_q[4*int'(idx_q) +: 4];
    bi    = op_q ? (4'd9 - b_dig) : b_dig;
    s     = {1'b0, a_dig} + {1'b0, bi} + {4'd0, c_q};
    if (s > 5'd9) begin
      digit = 4'(s - 5'd10);
      c_out = 1'b1;
    end else begin
      digit = s[3:0];
      c_out = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    idx_d    = idx_q;
    result_d = result_q;
    cy_d     = cy_q;
    err_d    = err_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          op_d     = bus.op;
          result_d = '0;
          cy_d     = 1'b0;
          idx_d    = '0;
          if (any_bad) begin
            err_d   = 1'b1;
            c_d     = 1'b0;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            c_d     = bus.op;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        result_d[4*int'(idx_q) +: 4] = digit;
        c_d = c_out;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        cy_d    = err_q ? 1'b0 : (op_q ? ~c_q : c_q);
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cy_q     <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cy_q     <= cy_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cy     = cy_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_addsub_serial.sv
// tb/tb_bcd_addsub_serial.sv - directed vector bench for bcd_addsub_serial, DIGITS=4
module tb_bcd_addsub_serial;
  localparam int DIGITS = 4;

  logic clk;
  logic rst_b;
  int   n_tests;
  int   n_fail;

  bcd_addsub_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_addsub_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] res;
    logic        cy;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for done; checks latency, busy length and outputs.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic op,
                        input logic [15:0] res, input logic cy, input logic err,
                        input string tag);
    int lat;
    int nbusy;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.op    = op;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hAAAA;
    bus.op    = ~op;
    lat   = 0;
    nbusy = bus.busy ? 1 : 0;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) nbusy++;
    end
    check({tag, " latency"}, lat, err ? 1 : DIGITS + 1);
    check({tag, " busy_cycles"}, nbusy, err ? 0 : DIGITS);
    check({tag, " result"}, {16'd0, bus.result}, {16'd0, res});
    check({tag, " cy"}, {31'd0, bus.cy}, {31'd0, cy});
    check({tag, " err"}, {31'd0, bus.err}, {31'd0, err});
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, " result_hold"}, {16'd0, bus.result}, {16'd0, res});
  endtask

  initial begin
    int lat;
    int gap;
    logic seen;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[4]  = '{16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5]  = '{16'h0010, 16'h0090, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6]  = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[8]  = '{16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0};
    vecs[10] = '{16'h0000, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[11] = '{16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_b     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy",   {31'd0, bus.busy}, 32'd0);
    check("reset done",   {31'd0, bus.done}, 32'd0);
    check("reset cy",     {31'd0, bus.cy},   32'd0);
    check("reset err",    {31'd0, bus.err},  32'd0);
    check("reset result", {16'd0, bus.result}, 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].cy, vecs[i].err,
             $sformatf("vec%0d", i));
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.op = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111; bus.op = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ignore latency", lat, DIGITS + 1);
    check("ignore result", {16'd0, bus.result}, 32'h6912);
    repeat (2) @(posedge clk);
    #1;
    check("ignore no_rerun", {31'd0, bus.busy}, 32'd0);

    // reset in the middle of RUN discards the operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h0001; bus.op = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    check("midrst busy",   {31'd0, bus.busy}, 32'd0);
    check("midrst done",   {31'd0, bus.done}, 32'd0);
    check("midrst result", {16'd0, bus.result}, 32'd0);
    check("midrst cy",     {31'd0, bus.cy},   32'd0);
    check("midrst err",    {31'd0, bus.err},  32'd0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    check("midrst no_done", {31'd0, seen}, 32'd0);
    run_op(16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, "post_rst");

    // start held high: one operation every DIGITS+2 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.op = 1'b0;
    lat = 0;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("stream first_result", {16'd0, bus.result}, 32'h0002);
    gap = 0;
    do begin
      @(posedge clk);
      #1;
      gap++;
    end while (!bus.done && gap < 30);
    bus.start = 1'b0;
    check("stream period", gap, DIGITS + 2);
    check("stream second_result", {16'd0, bus.result}, 32'h0002);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_addsub_serial.md
# bcd_addsub_serial

Digit-serial, parametrised multi-digit BCD adder/subtractor. It processes one BCD digit per clock, least-significant digit first, and uses a start/busy/done handshake. It generalises the single-digit BCD sum (units + tens output) to DIGITS-wide operands, adds ten's-complement subtraction and flags invalid input digits. It sits in the arithmetic datapath as a multi-cycle coprocessor.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst_b  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a−b); captured with start
- a  input  4*DIGITS  operand A, digit i at bits [4i+3:4i]; captured with start
- b  input  4*DIGITS  operand B, same layout; captured with start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- result  output  4*DIGITS  BCD result, held until the next accepted start
- cy  output  1  add: decimal carry out (sum ≥ 10^DIGITS); sub: borrow (a < b)
- err  output  1  an input digit was > 9; held with result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when start=1, capture a, b, op into internal registers, clear result/cy/err, load digit index = 0.
  - If any captured digit of a or b is > 9: go to DONE with err=1, result=0, cy=0.
  - Otherwise go to RUN with carry register c = op (1 for sub, 0 for add).
- RUN, one digit per cycle, index i = 0..DIGITS−1:
  - bi = op ? (9 − b_i) : b_i.
  - 5-bit sum s = a_i + bi + c.
  - If s > 9: digit = s − 10 and c = 1. Otherwise digit = s and c = 0.
  - Write digit to result[4i+3:4i].
  - After i = DIGITS−1, go to DONE.
- DONE: done=1 for exactly one cycle.
  - cy = op ? ~c : c. On the err path, cy = 0.
  - Next state is IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- Subtraction with a < b yields the ten's complement, 10^DIGITS − (b − a), with cy=1.
- The index counter is $clog2(DIGITS) bits wide; it never wraps past DIGITS−1.

## Timing
- Reset (rst_b=0 at a rising edge):
  - state = IDLE;
  - busy, done, cy, err = 0;
  - result = 0;
  - internal carry and index = 0.
- Reset has priority over every other event, including mid-RUN. The operation in flight is discarded and no done is produced.
- start is accepted at edge k:
  - busy = 1 from edge k to edge k+DIGITS;
  - done = 1 after edge k+DIGITS+1, for one cycle;
  - total latency is DIGITS+1 cycles.
- Invalid-digit path: done is high after edge k+1 (latency 1) and busy never rises.
- start held high continuously: the next operation is accepted on the first IDLE edge after done, giving throughput of one operation per DIGITS+2 cycles.
- result digits update progressively during RUN. They are valid only when done=1, and remain stable afterwards until the next accepted start.
- Input changes on a, b, op outside the start-accept edge have no effect.

## Test plan
- Add, DIGITS=4: a=0x1234, b=0x5678, op=0.
  - Required: result=0x6912, cy=0, err=0.
  - done exactly 5 cycles after start is accepted; busy high for 4 cycles.
- Add carry chain: a=0x9999, b=0x0001, op=0.
  - Required: result=0x0000, cy=1.
- Subtract: a=0x5000, b=0x1234, op=1.
  - Required: result=0x3766, cy=0.
- Subtract underflow: a=0x0001, b=0x0002, op=1.
  - Required: result=0x9999, cy=1.
- Invalid digit: a=0x12A4, b=0x0000.
  - Required: err=1, result=0, cy=0, busy stays 0, done 1 cycle after acceptance.
  - The next valid op clears err.
- Reset mid-RUN and start while busy:
  - Pulse start with a second operand set during RUN; it must be ignored and the first result returned.
  - Then start a new op and drop rst_b for one edge during RUN. All outputs must read 0 and no done pulse is produced.
  - A subsequent start computes correctly.
